// File: rtl/game_pkg.sv
// Shared types for the turn-order controller: move codes, loss causes, FSM states.
package game_pkg;
    localparam logic [2:0] MV_PASS    = 3'd0;
    localparam logic [2:0] MV_SKIP    = 3'd1;
    localparam logic [2:0] MV_REVERSE = 3'd2;
    localparam logic [2:0] MV_REPEAT  = 3'd3;

    typedef enum logic [1:0] {
        CAUSE_ILLEGAL    = 2'd0,
        CAUSE_WRONG_TURN = 2'd1,
        CAUSE_TIMEOUT    = 2'd2
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_e;
endpackage

// File: rtl/turn_game_ctrl_if.sv
// Player inputs and game status outputs of the turn-order controller.
interface turn_game_ctrl_if
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS = 6,
    parameter int PID_W       = $clog2(NUM_PLAYERS)
);
    logic                     start;
    logic [NUM_PLAYERS-1:0]   player_valid;
    logic [3*NUM_PLAYERS-1:0] player_move;
    logic [PID_W-1:0]         turn;
    logic                     direction;
    logic                     playing;
    logic                     game_over;
    logic [PID_W-1:0]         loser;
    cause_e                   loss_cause;
    logic [15:0]              move_count;

    modport master (
        output start, player_valid, player_move,
        input  turn, direction, playing, game_over, loser, loss_cause, move_count
    );
    modport slave (
        input  start, player_valid, player_move,
        output turn, direction, playing, game_over, loser, loss_cause, move_count
    );
endinterface

// File: rtl/turn_game_ctrl_step.sv
// Next player index: cur moved 1 or 2 steps up/down, wrapping modulo NUM_PLAYERS.
module turn_step #(
    parameter int NUM_PLAYERS = 6,
    parameter int PID_W       = $clog2(NUM_PLAYERS)
) (
    input  logic [PID_W-1:0] cur,
    input  logic             dir,
    input  logic [1:0]       steps,
    output logic [PID_W-1:0] nxt
);
    localparam int W = PID_W + 2;
    localparam logic [W-1:0] N = W'(NUM_PLAYERS);

    logic [W-1:0] cur_w, stp_w, up, dn;

    assign cur_w = W'(cur);
    assign stp_w = W'(steps);

    // cur < N and steps <= 2 <= N, so one correction term is always enough
    always_comb begin
        up = cur_w + stp_w;
        if (up >= N) up = up - N;
        dn = (cur_w >= stp_w) ? cur_w - stp_w : cur_w + N - stp_w;
        nxt = dir ? PID_W'(dn) : PID_W'(up);
    end
endmodule

// File: rtl/turn_game_ctrl.sv
// Single-clock turn-order controller: tracks turn/direction, applies moves,
// and ends the game on illegal move, out-of-turn play or turn timeout.
module turn_game_ctrl
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS    = 6,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int PID_W          = $clog2(NUM_PLAYERS)
) (
    input  logic clk,
    input  logic reset_n,
    turn_game_ctrl_if.slave gif
);
    localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);

    state_e           state;
    logic [PID_W-1:0] turn_q, loser_q, wrong_pid, turn_nxt;
    logic             dir_q, playing_q, over_q, wrong_any, cur_valid, step_dir;
    cause_e           cause_q;
    logic [15:0]      cnt_q;
    logic [TMR_W-1:0] timer_q;
    logic [2:0]       cur_move;

    // lowest-index out-of-turn player; scanned high to low so the lowest wins
    always_comb begin
        wrong_any = 1'b0;
        wrong_pid = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (gif.player_valid[i] && PID_W'(i) != turn_q) begin
                wrong_any = 1'b1;
                wrong_pid = PID_W'(i);
            end
        end
    end

    always_comb begin
        cur_valid = 1'b0;
        cur_move  = MV_PASS;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (PID_W'(i) == turn_q) begin
                cur_valid = gif.player_valid[i];
                cur_move  = gif.player_move[3*i +: 3];
            end
        end
    end

    // REVERSE steps in the already-toggled direction
    assign step_dir = (cur_move == MV_REVERSE) ? ~dir_q : dir_q;

    turn_step #(.NUM_PLAYERS(NUM_PLAYERS), .PID_W(PID_W)) u_step (
        .cur   (turn_q),
        .dir   (step_dir),
        .steps ((cur_move == MV_SKIP) ? 2'd2 : 2'd1),
        .nxt   (turn_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            turn_q    <= '0;
            dir_q     <= 1'b0;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
            loser_q   <= '0;
            cause_q   <= CAUSE_ILLEGAL;
            cnt_q     <= '0;
            timer_q   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (gif.start) begin
                        state     <= ST_PLAY;
                        playing_q <= 1'b1;
                        over_q    <= 1'b0;
                        turn_q    <= '0;
                        dir_q     <= 1'b0;
                        cnt_q     <= '0;
                        timer_q   <= TMR_LOAD;
                        loser_q   <= '0;
                        cause_q   <= CAUSE_ILLEGAL;
                    end
                end
                ST_PLAY: begin
                    if (wrong_any) begin
                        state     <= ST_OVER;
                        playing_q <= 1'b0;
                        over_q    <= 1'b1;
                        loser_q   <= wrong_pid;
                        cause_q   <= CAUSE_WRONG_TURN;
                    end else if (cur_valid) begin
                        if (cur_move > MV_REPEAT) begin
                            state     <= ST_OVER;
                            playing_q <= 1'b0;
                            over_q    <= 1'b1;
                            loser_q   <= turn_q;
                            cause_q   <= CAUSE_ILLEGAL;
                        end else begin
                            if (cur_move != MV_REPEAT) turn_q <= turn_nxt;
                            if (cur_move == MV_REVERSE) dir_q <= ~dir_q;
                            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
                            timer_q <= TMR_LOAD;
                        end
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (timer_q == TMR_W'(1)) begin
                            state     <= ST_OVER;
                            playing_q <= 1'b0;
                            over_q    <= 1'b1;
                            loser_q   <= turn_q;
                            cause_q   <= CAUSE_TIMEOUT;
                        end else begin
                            timer_q <= timer_q - TMR_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign gif.turn       = turn_q;
    assign gif.direction  = dir_q;
    assign gif.playing    = playing_q;
    assign gif.game_over  = over_q;
    assign gif.loser      = loser_q;
    assign gif.loss_cause = cause_q;
    assign gif.move_count = cnt_q;
endmodule

// File: tb/tb_turn_game_ctrl.sv
// Directed-vector bench for turn_game_ctrl (6 players / timeout 8, plus a 2-player no-timeout instance).
module tb_turn_game_ctrl;
    import game_pkg::*;

    logic clk;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    turn_game_ctrl_if #(.NUM_PLAYERS(6)) gif ();
    turn_game_ctrl_if #(.NUM_PLAYERS(2)) g2 ();

    turn_game_ctrl #(.NUM_PLAYERS(6), .TIMEOUT_CYCLES(8)) dut (
        .clk (clk), .reset_n (reset_n), .gif (gif.slave)
    );
    turn_game_ctrl #(.NUM_PLAYERS(2), .TIMEOUT_CYCLES(0)) dut2 (
        .clk (clk), .reset_n (reset_n), .gif (g2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  valid;
        logic [2:0]  code;
        logic [2:0]  e_turn;
        logic        e_dir;
        logic [15:0] e_cnt;
        logic        e_over;
        logic [2:0]  e_loser;
        logic [1:0]  e_cause;
    } vec_t;

    vec_t tbl [18];

    function automatic logic [26:0] pk(logic [2:0] t, logic d, logic pl, logic ov,
                                       logic [2:0] lo, logic [1:0] ca, logic [15:0] c);
        return {t, d, pl, ov, lo, ca, c};
    endfunction

    // fields: turn, dir, playing, game_over, loser, cause, move_count
    task automatic chk(input string name, input logic [26:0] exp);
        logic [26:0] act;
        act = {gif.turn, gif.direction, gif.playing, gif.game_over, gif.loser,
               2'(gif.loss_cause), gif.move_count};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got t=%0d d=%0d pl=%0d ov=%0d lo=%0d ca=%0d cnt=%0d, want t=%0d d=%0d pl=%0d ov=%0d lo=%0d ca=%0d cnt=%0d",
                     name, act[26:24], act[23], act[22], act[21], act[20:18], act[17:16], act[15:0],
                     exp[26:24], exp[23], exp[22], exp[21], exp[20:18], exp[17:16], exp[15:0]);
        end
    endtask

    task automatic chk2(input string name, input logic t, input logic d, input logic pl, input logic [15:0] c);
        logic [18:0] act, exp;
        act = {g2.turn, g2.direction, g2.playing, g2.move_count};
        exp = {t, d, pl, c};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (turn,dir,playing,count)", name, act, exp);
        end
    endtask

    task automatic tick(input logic [5:0] v, input logic [2:0] code, input logic st);
        gif.player_valid = v;
        gif.player_move  = {6{code}};
        gif.start        = st;
        @(posedge clk);
        #1;
        gif.player_valid = '0;
        gif.start        = 1'b0;
    endtask

    task automatic tick2(input logic [1:0] v, input logic [2:0] code, input logic st);
        g2.player_valid = v;
        g2.player_move  = {2{code}};
        g2.start        = st;
        @(posedge clk);
        #1;
        g2.player_valid = '0;
        g2.start        = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{6'b000001, MV_PASS,    3'd1, 1'b0, 16'd1,  1'b0, 3'd0, 2'd0};
        tbl[1]  = '{6'b000010, MV_PASS,    3'd2, 1'b0, 16'd2,  1'b0, 3'd0, 2'd0};
        tbl[2]  = '{6'b000100, MV_PASS,    3'd3, 1'b0, 16'd3,  1'b0, 3'd0, 2'd0};
        tbl[3]  = '{6'b001000, MV_PASS,    3'd4, 1'b0, 16'd4,  1'b0, 3'd0, 2'd0};
        tbl[4]  = '{6'b010000, MV_SKIP,    3'd0, 1'b0, 16'd5,  1'b0, 3'd0, 2'd0};
        tbl[5]  = '{6'b000001, MV_REPEAT,  3'd0, 1'b0, 16'd6,  1'b0, 3'd0, 2'd0};
        tbl[6]  = '{6'b000001, MV_REVERSE, 3'd5, 1'b1, 16'd7,  1'b0, 3'd0, 2'd0};
        tbl[7]  = '{6'b100000, MV_SKIP,    3'd3, 1'b1, 16'd8,  1'b0, 3'd0, 2'd0};
        tbl[8]  = '{6'b001000, MV_PASS,    3'd2, 1'b1, 16'd9,  1'b0, 3'd0, 2'd0};
        tbl[9]  = '{6'b000000, MV_PASS,    3'd2, 1'b1, 16'd9,  1'b0, 3'd0, 2'd0};
        tbl[10] = '{6'b000100, MV_PASS,    3'd1, 1'b1, 16'd10, 1'b0, 3'd0, 2'd0};
        tbl[11] = '{6'b000010, MV_PASS,    3'd0, 1'b1, 16'd11, 1'b0, 3'd0, 2'd0};
        tbl[12] = '{6'b000001, MV_PASS,    3'd5, 1'b1, 16'd12, 1'b0, 3'd0, 2'd0};
        tbl[13] = '{6'b100000, MV_REVERSE, 3'd0, 1'b0, 16'd13, 1'b0, 3'd0, 2'd0};
        tbl[14] = '{6'b000001, MV_SKIP,    3'd2, 1'b0, 16'd14, 1'b0, 3'd0, 2'd0};
        tbl[15] = '{6'b000100, MV_REPEAT,  3'd2, 1'b0, 16'd15, 1'b0, 3'd0, 2'd0};
        tbl[16] = '{6'b001100, MV_PASS,    3'd2, 1'b0, 16'd15, 1'b1, 3'd3, 2'd1};
        tbl[17] = '{6'b000100, MV_PASS,    3'd2, 1'b0, 16'd15, 1'b1, 3'd3, 2'd1};

        reset_n = 1'b0;
        gif.start = 1'b0; gif.player_valid = '0; gif.player_move = '0;
        g2.start  = 1'b0; g2.player_valid  = '0; g2.player_move  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", pk(0, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b1;

        tick('0, MV_PASS, 1'b1);
        chk("start", pk(0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].valid, tbl[i].code, 1'b0);
            chk($sformatf("vec%0d", i), pk(tbl[i].e_turn, tbl[i].e_dir, ~tbl[i].e_over, tbl[i].e_over,
                                           tbl[i].e_loser, tbl[i].e_cause, tbl[i].e_cnt));
        end

        // restart from OVER clears loser/cause, then an illegal code
        tick('0, MV_PASS, 1'b1);
        chk("restart", pk(0, 0, 1, 0, 0, 0, 0));
        tick(6'b000001, MV_PASS, 1'b0);
        chk("pass_to_1", pk(1, 0, 1, 0, 0, 0, 1));
        tick(6'b000010, 3'd5, 1'b0);
        chk("illegal", pk(1, 0, 0, 1, 1, 0, 1));

        // timeout on the 8th idle edge after start
        tick('0, MV_PASS, 1'b1);
        chk("restart2", pk(0, 0, 1, 0, 0, 0, 0));
        for (int j = 1; j <= 7; j++) begin
            tick('0, MV_PASS, 1'b0);
            chk($sformatf("idle%0d", j), pk(0, 0, 1, 0, 0, 0, 0));
        end
        tick('0, MV_PASS, 1'b0);
        chk("timeout", pk(0, 0, 0, 1, 0, 2, 0));

        // a legal move reloads the timer; start during PLAY is ignored
        tick('0, MV_PASS, 1'b1);
        repeat (4) tick('0, MV_PASS, 1'b0);
        chk("idle4", pk(0, 0, 1, 0, 0, 0, 0));
        tick(6'b000001, MV_PASS, 1'b0);
        chk("reload_move", pk(1, 0, 1, 0, 0, 0, 1));
        tick('0, MV_PASS, 1'b1);
        chk("start_in_play", pk(1, 0, 1, 0, 0, 0, 1));
        for (int j = 2; j <= 7; j++) begin
            tick('0, MV_PASS, 1'b0);
            chk($sformatf("reload_idle%0d", j), pk(1, 0, 1, 0, 0, 0, 1));
        end
        tick('0, MV_PASS, 1'b0);
        chk("timeout_after_reload", pk(1, 0, 0, 1, 1, 2, 1));

        // asynchronous reset mid-game
        tick('0, MV_PASS, 1'b1);
        tick(6'b000001, MV_PASS, 1'b0);
        tick(6'b000010, MV_REVERSE, 1'b0);
        chk("pre_reset", pk(0, 1, 1, 0, 0, 0, 2));
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", pk(0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(6'b000001, MV_PASS, 1'b0);
        chk("idle_ignores_play", pk(0, 0, 0, 0, 0, 0, 0));

        // two players, timeout disabled
        tick2('0, MV_PASS, 1'b1);
        chk2("n2_start", 0, 0, 1, 0);
        tick2(2'b01, MV_SKIP, 1'b0);
        chk2("n2_skip_same", 0, 0, 1, 1);
        tick2(2'b01, MV_PASS, 1'b0);
        chk2("n2_pass", 1, 0, 1, 2);
        tick2(2'b10, MV_REVERSE, 1'b0);
        chk2("n2_reverse", 0, 1, 1, 3);
        repeat (12) tick2('0, MV_PASS, 1'b0);
        chk2("n2_no_timeout", 0, 1, 1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
